// File: rtl/acpu_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU: opcodes, FSM states, ALU selects.
package acpu_pkg;

  localparam int unsigned DataWDefault = 8;
  localparam int unsigned AddrWDefault = 12;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpLdm  = 4'h2;
  localparam logic [3:0] OpStm  = 4'h3;
  localparam logic [3:0] OpAdd  = 4'h4;
  localparam logic [3:0] OpSub  = 4'h5;
  localparam logic [3:0] OpAnd  = 4'h6;
  localparam logic [3:0] OpOr   = 4'h7;
  localparam logic [3:0] OpXor  = 4'h8;
  localparam logic [3:0] OpAddi = 4'h9;
  localparam logic [3:0] OpJmp  = 4'hA;
  localparam logic [3:0] OpJz   = 4'hB;
  localparam logic [3:0] OpJc   = 4'hC;
  localparam logic [3:0] OpIn   = 4'hD;
  localparam logic [3:0] OpOut  = 4'hE;
  localparam logic [3:0] OpHlt  = 4'hF;

  typedef enum logic [2:0] {
    StFetch, StExec, StMem, StExec2, StWaitIn, StHalt
  } state_e;

  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluPass
  } alu_op_e;

endpackage

// File: rtl/acpu_alu.sv
// Combinational ALU: add/sub/and/or/xor/pass with zero and carry/borrow out.
module acpu_alu import acpu_pkg::*; #(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  alu_op_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o,
  output logic              c_o,
  output logic              z_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Result select; c_o is carry-out for add and borrow (a < b) for sub.
  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i};
    diff = {1'b0, a_i} - {1'b0, b_i};
    y_o  = b_i;
    c_o  = 1'b0;
    unique case (op_i)
      AluAdd:  begin y_o = sum[DATA_W-1:0];  c_o = sum[DATA_W];  end
      AluSub:  begin y_o = diff[DATA_W-1:0]; c_o = diff[DATA_W]; end
      AluAnd:  y_o = a_i & b_i;
      AluOr:   y_o = a_i | b_i;
      AluXor:  y_o = a_i ^ b_i;
      AluPass: y_o = b_i;
      default: y_o = b_i;
    endcase
    z_o = (y_o == '0);
  end

endmodule

// File: rtl/accum_cpu_mc.sv
// Multi-cycle accumulator CPU: FSM-sequenced fetch/execute with handshaked memories and input.
module accum_cpu_mc import acpu_pkg::*; #(
  parameter int unsigned        DATA_W   = DataWDefault,
  parameter int unsigned        ADDR_W   = AddrWDefault,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  localparam int unsigned       INS_W    = 4 + ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INS_W-1:0]  imem_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              inp_valid_i,
  input  logic [DATA_W-1:0] inp_data_i,
  output logic              inp_ack_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              halted_o
);

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INS_W-1:0]    ir_q;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   mdr_q;
  logic                z_q;
  logic                c_q;
  logic                imem_req_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic                dmem_req_q;
  logic                dmem_we_q;
  logic [ADDR_W-1:0]   dmem_addr_q;
  logic [DATA_W-1:0]   dmem_wdata_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                halted_q;

  logic [3:0]          op;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   imm;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   branch_pc;
  alu_op_e             alu_op;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_c;
  logic                alu_z;

  assign op      = ir_q[INS_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign imm     = operand[DATA_W-1:0];
  assign pc_inc  = pc_q + 1'b1;

  // Next PC for EXEC-class completion; flags are the ones held entering EXEC.
  always_comb begin
    branch_pc = pc_inc;
    case (op)
      OpJmp:   branch_pc = operand;
      OpJz:    if (z_q) branch_pc = operand;
      OpJc:    if (c_q) branch_pc = operand;
      default: branch_pc = pc_inc;
    endcase
  end

  // ALU operation and B source: immediate in EXEC, MDR in EXEC2.
  always_comb begin
    alu_op = AluPass;
    case (op)
      OpAdd, OpAddi: alu_op = AluAdd;
      OpSub:         alu_op = AluSub;
      OpAnd:         alu_op = AluAnd;
      OpOr:          alu_op = AluOr;
      OpXor:         alu_op = AluXor;
      default:       alu_op = AluPass;
    endcase
    alu_b = (state_q == StExec2) ? mdr_q : imm;
  end

  acpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i (alu_op),
    .a_i  (acc_q),
    .b_i  (alu_b),
    .y_o  (alu_y),
    .c_o  (alu_c),
    .z_o  (alu_z)
  );

  // Sequencer, architectural state and registered bus outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      acc_q        <= '0;
      mdr_q        <= '0;
      z_q          <= 1'b0;
      c_q          <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StFetch: begin
          // First FETCH after reset raises req; an ack without our req is ignored.
          if (!imem_req_q) begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
          end else if (imem_ack_i) begin
            ir_q       <= imem_data_i;
            imem_req_q <= 1'b0;
            state_q    <= StExec;
          end
        end
        StExec: begin
          case (op)
            OpLdm, OpStm, OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= (op == OpStm);
              dmem_addr_q  <= operand;
              dmem_wdata_q <= acc_q;
              state_q      <= StMem;
            end
            OpIn:  state_q <= StWaitIn;
            OpHlt: begin
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end
            default: begin
              if (op == OpLdi || op == OpAddi) begin
                acc_q <= alu_y;
                z_q   <= alu_z;
              end
              if (op == OpAddi) c_q <= alu_c;
              if (op == OpOut) begin
                out_data_q  <= acc_q;
                out_valid_q <= 1'b1;
              end
              pc_q        <= branch_pc;
              imem_addr_q <= branch_pc;
              imem_req_q  <= 1'b1;
              state_q     <= StFetch;
            end
          endcase
        end
        StMem: begin
          if (dmem_ack_i) begin
            mdr_q      <= dmem_rdata_i;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            state_q    <= StExec2;
          end
        end
        StExec2: begin
          if (op != OpStm) begin
            acc_q <= alu_y;
            z_q   <= alu_z;
            if (op == OpAdd || op == OpSub) c_q <= alu_c;
          end
          pc_q        <= pc_inc;
          imem_addr_q <= pc_inc;
          imem_req_q  <= 1'b1;
          state_q     <= StFetch;
        end
        StWaitIn: begin
          if (inp_valid_i) begin
            acc_q       <= inp_data_i;
            z_q         <= (inp_data_i == '0);
            pc_q        <= pc_inc;
            imem_addr_q <= pc_inc;
            imem_req_q  <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Input ack must be visible in the very cycle the word is consumed.
  assign inp_ack_o    = (state_q == StWaitIn) && inp_valid_i;
  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = imem_addr_q;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign halted_o     = halted_q;

endmodule

// File: tb/tb_accum_cpu_mc.sv
// Directed bench for accum_cpu_mc with an output scoreboard and simple memory models.
module tb_accum_cpu_mc;

  localparam logic [3:0] NOP = 4'h0, LDI = 4'h1, STM = 4'h3, SUB = 4'h5, ADDI = 4'h9;
  localparam logic [3:0] JMP = 4'hA, JZ = 4'hB, JC = 4'hC, IN = 4'hD, OUT = 4'hE, HLT = 4'hF;

  logic        clk, rst;
  logic        imem_req_o, imem_ack_i;
  logic [11:0] imem_addr_o;
  logic [15:0] imem_data_i;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [11:0] dmem_addr_o;
  logic [7:0]  dmem_wdata_o, dmem_rdata_i;
  logic        inp_valid_i, inp_ack_o, out_valid_o, halted_o;
  logic [7:0]  inp_data_i, out_data_o;

  logic [15:0] imem [0:4095];
  int          dmem_delay;
  int          dcnt;
  logic        dmem_late_ack;
  int          wr_cnt;
  logic [11:0] last_wr_addr;
  logic [7:0]  last_wr_data;
  int          ack_cnt;
  logic [7:0]  exp_q [$];
  int          checks;
  int          failures;

  accum_cpu_mc dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .inp_valid_i  (inp_valid_i),
    .inp_data_i   (inp_data_i),
    .inp_ack_o    (inp_ack_o),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .halted_o     (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: ack tied high, data read combinationally.
  assign imem_ack_i  = 1'b1;
  assign imem_data_i = imem[imem_addr_o];
  // Data memory: fixed read contents, ack after dmem_delay waiting cycles.
  assign dmem_rdata_i = (dmem_addr_o == 12'h020) ? 8'h02 : 8'h00;
  assign dmem_ack_i   = (dmem_req_o && (dcnt >= dmem_delay)) || dmem_late_ack;

  initial begin
    dcnt = 0; wr_cnt = 0; ack_cnt = 0; last_wr_addr = '0; last_wr_data = '0;
  end

  always @(posedge clk) begin
    if (!dmem_req_o || dmem_ack_i) dcnt <= 0;
    else dcnt <= dcnt + 1;
    if (dmem_req_o && dmem_ack_i && dmem_we_o) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= dmem_addr_o;
      last_wr_data <= dmem_wdata_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: OUT results popped and compared when out_valid_o pulses.
  always @(negedge clk) begin
    if (inp_ack_o) ack_cnt <= ack_cnt + 1;
    if (out_valid_o) begin
      check("out_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("out_data", 64'(out_data_o), 64'(exp_q.pop_front()));
    end
  end

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] a);
    return {op, a};
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
                inp_ack_o, out_data_o, out_valid_o, halted_o});
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) imem[i] = ins(HLT, 12'h000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
  endtask

  // Returns the address of the next accepted fetch and the negedges it took.
  task automatic next_fetch(output logic [11:0] a, output int cyc);
    logic got;
    got = 1'b0; a = '0; cyc = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (imem_req_o && imem_ack_i) begin
        got = 1'b1;
        a   = imem_addr_o;
      end
    end
    check("fetch_within_budget", 64'(got), 64'd1);
  endtask

  task automatic wait_dreq();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (dmem_req_o) got = 1'b1;
    end
    check("dreq_within_budget", 64'(got), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    int c, c1, c2, w0, k0, req_seen;
    checks = 0; failures = 0;
    rst = 1'b1; inp_valid_i = 1'b0; inp_data_i = '0;
    dmem_delay = 0; dmem_late_ack = 1'b0;

    // 1: LDI 05; ADDI FB -> 0, Z=1, C=1 (seen through OUT, JZ and JC)
    clear_imem();
    imem[0] = ins(LDI, 12'h005); imem[1] = ins(ADDI, 12'h0FB); imem[2] = ins(OUT, 12'h000);
    imem[3] = ins(JZ, 12'h040); imem[12'h040] = ins(JC, 12'h050);
    exp_q.push_back(8'h00);
    do_reset();
    next_fetch(a, c);  check("t1_fetch0", 64'(a), 64'h000);
    next_fetch(a, c1); check("t1_fetch1", 64'(a), 64'h001);
    next_fetch(a, c2); check("t1_fetch2", 64'(a), 64'h002);
    check("t1_two_op_cycles", 64'(c1 + c2), 64'd4);
    next_fetch(a, c);  check("t1_fetch3", 64'(a), 64'h003);
    next_fetch(a, c);  check("t1_jz_taken", 64'(a), 64'h040);
    next_fetch(a, c);  check("t1_jc_taken", 64'(a), 64'h050);
    repeat (2) @(negedge clk);
    check("t1_halted", 64'(halted_o), 64'd1);
    check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // 2: STM 0x010 with ACC=0x3C and a 3-cycle ack delay
    clear_imem();
    imem[0] = ins(LDI, 12'h03C); imem[1] = ins(STM, 12'h010);
    dmem_delay = 3;
    do_reset();
    w0 = wr_cnt;
    wait_dreq();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("t2_bus_stable", 64'({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o}),
            64'({1'b1, 1'b1, 12'h010, 8'h3C}));
      check("t2_ack_timing", 64'(dmem_ack_i), 64'(k == 3));
    end
    @(negedge clk);
    check("t2_req_dropped", 64'(dmem_req_o), 64'd0);
    check("t2_one_write", 64'(wr_cnt - w0), 64'd1);
    check("t2_write_data", 64'({last_wr_addr, last_wr_data}), 64'({12'h010, 8'h3C}));
    next_fetch(a, c);  check("t2_fetch_after_stm", 64'(a), 64'h002);

    // 3: LDI 01; SUB M[0x020]=2 -> 0xFF with borrow; JZ not taken, JC taken
    clear_imem();
    imem[0] = ins(LDI, 12'h001); imem[1] = ins(SUB, 12'h020); imem[2] = ins(OUT, 12'h000);
    imem[3] = ins(JZ, 12'h0F0); imem[4] = ins(JC, 12'h100);
    dmem_delay = 0;
    exp_q.push_back(8'hFF);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      next_fetch(a, c);
      check("t3_seq_fetch", 64'(a), 64'(i));
    end
    next_fetch(a, c);  check("t3_jc_borrow_taken", 64'(a), 64'h100);
    repeat (2) @(negedge clk);
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // 4: IN with the input held off for 5 cycles, then OUT
    clear_imem();
    imem[0] = ins(IN, 12'h000); imem[1] = ins(OUT, 12'h000);
    exp_q.push_back(8'hA7);
    do_reset();
    k0 = ack_cnt;
    next_fetch(a, c);  check("t4_fetch_in", 64'(a), 64'h000);
    repeat (5) @(negedge clk);
    check("t4_no_early_ack", 64'(ack_cnt - k0), 64'd0);
    @(posedge clk); #1;
    inp_valid_i = 1'b1; inp_data_i = 8'hA7;
    @(posedge clk); #1;
    inp_valid_i = 1'b0; inp_data_i = 8'h00;
    next_fetch(a, c);  check("t4_fetch_out", 64'(a), 64'h001);
    check("t4_single_ack", 64'(ack_cnt - k0), 64'd1);
    next_fetch(a, c);
    repeat (2) @(negedge clk);
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // 5: PC wrap from 0xFFF, second pass sets carry, then HLT
    clear_imem();
    imem[0] = ins(ADDI, 12'h0FF); imem[1] = ins(JC, 12'h003); imem[2] = ins(JMP, 12'hFFF);
    imem[12'hFFF] = ins(NOP, 12'h000);
    do_reset();
    next_fetch(a, c);  check("t5_f0", 64'(a), 64'h000);
    next_fetch(a, c);  check("t5_f1", 64'(a), 64'h001);
    next_fetch(a, c);  check("t5_jc_not_taken", 64'(a), 64'h002);
    next_fetch(a, c);  check("t5_jmp", 64'(a), 64'hFFF);
    next_fetch(a, c);  check("t5_wrap", 64'(a), 64'h000);
    next_fetch(a, c);  check("t5_f1_again", 64'(a), 64'h001);
    next_fetch(a, c);  check("t5_jc_taken", 64'(a), 64'h003);
    repeat (2) @(negedge clk);
    check("t5_halted", 64'(halted_o), 64'd1);
    req_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req_o || dmem_req_o) req_seen++;
    end
    check("t5_no_req_in_halt", 64'(req_seen), 64'd0);
    check("t5_still_halted", 64'(halted_o), 64'd1);

    // 6: reset in the middle of a stalled MEM access
    clear_imem();
    imem[0] = ins(STM, 12'h030);
    dmem_delay = 1000;
    do_reset();
    w0 = wr_cnt;
    wait_dreq();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("t6_async_reset_outputs", all_outs(), 64'd0);
    dmem_late_ack = 1'b1;
    dmem_delay = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    next_fetch(a, c);  check("t6_refetch_reset_pc", 64'(a), 64'h000);
    check("t6_late_ack_no_write", 64'(wr_cnt - w0), 64'd0);
    dmem_late_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_stm_after_reset", 64'(wr_cnt - w0), 64'd1);
    check("t6_write_data", 64'({last_wr_addr, last_wr_data}), 64'({12'h030, 8'h00}));

    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
